// File: rtl/fetch_unit_pkg.sv
// Shared constants and the instruction-buffer entry layout for the fetch front end.
package fetch_unit_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and a head read straight from the storage registers.
module fetch_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       push_i,
   input  logic [W-1:0]               din_i,
   input  logic                       pop_i,
   output logic [W-1:0]               head_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [CW-1:0] cnt_q;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         // The caller's credit scheme must keep these from ever firing.
         assert (!(push_i && !pop_i && cnt_q == CW'(DEPTH)));
         assert (!(pop_i && cnt_q == '0));
         if (push_i) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= bump(wr_q);
         end
         if (pop_i) rd_q <= bump(rd_q);
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end

   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch front end: PC, credit-limited IROM requests, response buffering and redirect flush.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic        irom_req,
   input  logic        irom_gnt,
   output logic [31:0] irom_addr,
   input  logic        irom_rvalid,
   input  logic [31:0] irom_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4
);

   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int SW = CW + 2;

   logic [31:0]   pc_q, pc_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] pend_cnt, buf_cnt;
   logic [31:0]   pend_head;
   fetch_entry_t  buf_head;
   logic          grant, pop_now, pend_pop, buf_push;
   logic [SW-1:0] used;

   assign pop_now = id_valid & id_ready;
   assign grant   = irom_req & irom_gnt;

   // Every credit is either in flight (live or to be dropped) or sitting in the buffer.
   assign used     = SW'(drop_q) + SW'(pend_cnt) + SW'(buf_cnt) - SW'(pop_now);
   assign irom_req = !redirect_valid && (used < SW'(BUF_DEPTH));
   assign irom_addr = pc_q;

   always_comb begin
      pc_d     = pc_q;
      drop_d   = drop_q;
      pend_pop = 1'b0;
      buf_push = 1'b0;
      if (redirect_valid) begin
         pc_d   = redirect_pc & ~32'h3;
         drop_d = drop_q + pend_cnt - CW'(irom_rvalid);
      end else begin
         if (grant) pc_d = pc_q + 32'd4;
         if (irom_rvalid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - 1'b1;
            end else begin
               pend_pop = 1'b1;
               buf_push = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         drop_q <= drop_d;
      end
   end

   fetch_fifo #(.W(32), .DEPTH(BUF_DEPTH)) u_pend (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_valid),
      .push_i  (grant),
      .din_i   (pc_q),
      .pop_i   (pend_pop),
      .head_o  (pend_head),
      .count_o (pend_cnt)
   );

   fetch_fifo #(.W(64), .DEPTH(BUF_DEPTH)) u_buf (
      .clk     (clk),
      .rst     (rst),
      .flush_i (redirect_valid),
      .push_i  (buf_push),
      .din_i   ({pend_head, irom_rdata}),
      .pop_i   (pop_now),
      .head_o  (buf_head),
      .count_o (buf_cnt)
   );

   assign id_valid = (buf_cnt != '0);
   assign id_inst  = buf_head.inst;
   assign id_pc    = buf_head.pc;
   assign id_pc4   = buf_head.pc + 32'd4;

endmodule
